// File: rtl/selen_bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, owner IDs and
// the default bus-error timeout.
package selen_bus_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnI = 2'd1,
        StOwnD = 2'd2,
        StErr  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OwnerInstr = 1'b0,
        OwnerData  = 1'b1
    } owner_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/bus_timeout.sv
// Watchdog counter for an outstanding memory strobe; flags expiry once TIMEOUT-1
// unacknowledged strobe cycles have been counted.
module bus_timeout
    import selen_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_count) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one memory port, with cycle
// locking, alternating tie-break and a strobe timeout that raises a bus error.
module bus_arbiter
    import selen_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cyc,
    input  logic        i_stb,
    input  logic [31:0] i_adr,
    output logic [31:0] i_dat,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_cyc,
    input  logic        d_stb,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_dat_w,
    output logic [31:0] d_dat_r,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_cyc,
    output logic        m_stb,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat_w,
    input  logic [31:0] m_dat_r,
    input  logic        m_ack,
    output logic [1:0]  grant
);

    arb_state_e r_state, w_state_nxt;
    owner_e     r_last_owner, w_last_nxt;
    logic       w_own, w_expired, w_tmr_clear, w_tmr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last_owner <= OwnerData;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    // Counter is held clear outside ownership, so every OWN_x entry starts from zero.
    assign w_own       = (r_state == StOwnI) || (r_state == StOwnD);
    assign w_tmr_clear = !w_own || m_ack;
    assign w_tmr_count = m_stb && !m_ack;

    bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmr_clear),
        .i_count  (w_tmr_count),
        .o_expired(w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_owner;
        m_cyc       = 1'b0;
        m_stb       = 1'b0;
        m_we        = 1'b0;
        m_sel       = 4'b0000;
        m_adr       = 32'd0;
        m_dat_w     = 32'd0;
        i_dat       = 32'd0;
        i_ack       = 1'b0;
        i_err       = 1'b0;
        d_dat_r     = 32'd0;
        d_ack       = 1'b0;
        d_err       = 1'b0;
        grant       = 2'b00;

        unique case (r_state)
            StIdle: begin
                if (i_cyc && d_cyc) begin
                    w_state_nxt = (r_last_owner == OwnerData) ? StOwnI : StOwnD;
                end else if (i_cyc) begin
                    w_state_nxt = StOwnI;
                end else if (d_cyc) begin
                    w_state_nxt = StOwnD;
                end
            end
            StOwnI: begin
                grant = 2'b01;
                m_cyc = i_cyc;
                m_stb = i_stb;
                m_sel = 4'b1111;
                m_adr = i_adr;
                i_ack = m_ack;
                i_dat = m_dat_r;
                // Release takes priority over a coincident timeout.
                if (!i_cyc) begin
                    w_state_nxt = StIdle;
                    w_last_nxt  = OwnerInstr;
                end else if (w_expired && !m_ack) begin
                    w_state_nxt = StErr;
                    w_last_nxt  = OwnerInstr;
                end
            end
            StOwnD: begin
                grant   = 2'b10;
                m_cyc   = d_cyc;
                m_stb   = d_stb;
                m_we    = d_we;
                m_sel   = d_sel;
                m_adr   = d_adr;
                m_dat_w = d_dat_w;
                d_ack   = m_ack;
                d_dat_r = m_dat_r;
                if (!d_cyc) begin
                    w_state_nxt = StIdle;
                    w_last_nxt  = OwnerData;
                end else if (w_expired && !m_ack) begin
                    w_state_nxt = StErr;
                    w_last_nxt  = OwnerData;
                end
            end
            StErr: begin
                // last_owner already names the master that timed out.
                i_err       = (r_last_owner == OwnerInstr);
                d_err       = (r_last_owner == OwnerData);
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected master responses,
// a monitor pops and compares them whenever an ack or err appears.
module tb_bus_arbiter;

    localparam int unsigned TO = 4;
    localparam logic [1:0] K_IACK = 2'd0;
    localparam logic [1:0] K_IERR = 2'd1;
    localparam logic [1:0] K_DACK = 2'd2;
    localparam logic [1:0] K_DERR = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cyc, i_stb;
    logic [31:0] i_adr, i_dat;
    logic        i_ack, i_err;
    logic        d_cyc, d_stb, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_adr, d_dat_w, d_dat_r;
    logic        d_ack, d_err;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic        m_ack;
    logic [1:0]  grant;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    bus_arbiter #(
        .TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cyc  (i_cyc),
        .i_stb  (i_stb),
        .i_adr  (i_adr),
        .i_dat  (i_dat),
        .i_ack  (i_ack),
        .i_err  (i_err),
        .d_cyc  (d_cyc),
        .d_stb  (d_stb),
        .d_we   (d_we),
        .d_sel  (d_sel),
        .d_adr  (d_adr),
        .d_dat_w(d_dat_w),
        .d_dat_r(d_dat_r),
        .d_ack  (d_ack),
        .d_err  (d_err),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_we   (m_we),
        .m_sel  (m_sel),
        .m_adr  (m_adr),
        .m_dat_w(m_dat_w),
        .m_dat_r(m_dat_r),
        .m_ack  (m_ack),
        .grant  (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic expect_resp(input logic [1:0] kind, input logic [31:0] data);
        resp_t r;
        r.kind = kind;
        r.data = data;
        exp_q.push_back(r);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc   = 1'b0;
        i_stb   = 1'b0;
        i_adr   = 32'd0;
        d_cyc   = 1'b0;
        d_stb   = 1'b0;
        d_we    = 1'b0;
        d_sel   = 4'd0;
        d_adr   = 32'd0;
        d_dat_w = 32'd0;
    endtask

    // Monitor: responses are compared against the scoreboard; reset must silence everything.
    logic [1:0]  mon_kind;
    logic [31:0] mon_data;
    resp_t       mon_exp;
    int          mon_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl_outputs",
                32'({m_cyc, m_stb, m_we, m_sel, grant, i_ack, i_err, d_ack, d_err}), 32'd0);
            chk("reset_data_outputs", m_adr | m_dat_w | i_dat | d_dat_r, 32'd0);
        end else if (i_ack || i_err || d_ack || d_err) begin
            mon_n = int'(i_ack) + int'(i_err) + int'(d_ack) + int'(d_err);
            chk("resp_single", 32'(mon_n), 32'd1);
            mon_kind = i_ack ? K_IACK : (i_err ? K_IERR : (d_ack ? K_DACK : K_DERR));
            mon_data = i_ack ? i_dat : (d_ack ? d_dat_r : 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got kind %0d data %h, expected none",
                         mon_kind, mon_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp_kind", 32'(mon_kind), 32'(mon_exp.kind));
                if (mon_exp.kind == K_IACK || mon_exp.kind == K_DACK) begin
                    chk("resp_data", mon_data, mon_exp.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        idle_inputs();
        m_ack   = 1'b0;
        m_dat_r = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);

        // Fetch alone
        next_cyc(); rst_n = 1'b1;
        next_cyc(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h100;
        @(negedge clk);
        chk("t1_c0_mcyc", 32'(m_cyc), 32'd0);
        chk("t1_c0_grant", 32'(grant), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t1_c1_mcyc", 32'(m_cyc), 32'd1);
        chk("t1_c1_grant", 32'(grant), 32'd1);
        chk("t1_c1_madr", m_adr, 32'h100);
        chk("t1_c1_msel", 32'(m_sel), 32'hF);
        chk("t1_c1_mwe", 32'(m_we), 32'd0);
        next_cyc();
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'hDEADBEEF; expect_resp(K_IACK, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_c3_grant", 32'(grant), 32'd1);
        next_cyc(); m_ack = 1'b0; m_dat_r = 32'd0; i_cyc = 1'b0; i_stb = 1'b0;
        @(negedge clk);
        chk("t1_c4_grant", 32'(grant), 32'd1);
        chk("t1_c4_mcyc", 32'(m_cyc), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t1_c5_grant", 32'(grant), 32'd0);

        // Tie after reset: instruction first, then data, then instruction again
        next_cyc(); rst_n = 1'b0;
        next_cyc(); rst_n = 1'b1;
        next_cyc();
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h104;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h300;
        @(negedge clk);
        chk("t2_c0_grant", 32'(grant), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t2_tie_grant", 32'(grant), 32'd1);
        chk("t2_tie_madr", m_adr, 32'h104);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'h11111111; expect_resp(K_IACK, 32'h11111111);
        next_cyc(); m_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
        @(negedge clk);
        chk("t2_release_grant", 32'(grant), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("t2_idle_grant", 32'(grant), 32'd0);
        chk("t2_idle_mcyc", 32'(m_cyc), 32'd0);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'h22222222; expect_resp(K_DACK, 32'h22222222);
        @(negedge clk);
        chk("t2_data_grant", 32'(grant), 32'd2);
        chk("t2_data_madr", m_adr, 32'h300);
        next_cyc(); m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        next_cyc();
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h108; d_cyc = 1'b1; d_stb = 1'b1;
        @(negedge clk);
        chk("t2_idle2_grant", 32'(grant), 32'd0);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'h33333333; expect_resp(K_IACK, 32'h33333333);
        @(negedge clk);
        chk("t2_second_tie", 32'(grant), 32'd1);
        next_cyc(); m_ack = 1'b0; idle_inputs();
        next_cyc();
        @(negedge clk);
        chk("t2_end_grant", 32'(grant), 32'd0);

        // Lock: data write holds the port while instruction waits
        next_cyc();
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 32'h200; d_dat_w = 32'h55;
        d_sel = 4'b0001;
        next_cyc(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h400;
        @(negedge clk);
        chk("t3_grant", 32'(grant), 32'd2);
        chk("t3_mwe", 32'(m_we), 32'd1);
        chk("t3_madr", m_adr, 32'h200);
        chk("t3_mdatw", m_dat_w, 32'h55);
        chk("t3_msel", 32'(m_sel), 32'h1);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'd0; expect_resp(K_DACK, 32'd0);
        @(negedge clk);
        chk("t3_ack_madr", m_adr, 32'h200);
        next_cyc(); m_ack = 1'b0; d_stb = 1'b0;
        @(negedge clk);
        chk("t3_locked_grant", 32'(grant), 32'd2);
        chk("t3_locked_madr", m_adr, 32'h200);
        chk("t3_locked_mstb", 32'(m_stb), 32'd0);
        next_cyc(); d_cyc = 1'b0; d_we = 1'b0; d_sel = 4'd0; d_adr = 32'd0; d_dat_w = 32'd0;
        @(negedge clk);
        chk("t3_release_grant", 32'(grant), 32'd2);
        chk("t3_release_mcyc", 32'(m_cyc), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t3_idle_grant", 32'(grant), 32'd0);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'hA5A5A5A5; expect_resp(K_IACK, 32'hA5A5A5A5);
        @(negedge clk);
        chk("t3_pending_grant", 32'(grant), 32'd1);
        chk("t3_pending_madr", m_adr, 32'h400);
        next_cyc(); m_ack = 1'b0; idle_inputs();
        next_cyc();

        // Timeout: fetch never acknowledged
        next_cyc(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h500;
        next_cyc();
        @(negedge clk);
        chk("t4_c1_grant", 32'(grant), 32'd1);
        chk("t4_c1_mstb", 32'(m_stb), 32'd1);
        repeat (3) next_cyc();
        @(negedge clk);
        chk("t4_c4_grant", 32'(grant), 32'd1);
        next_cyc(); expect_resp(K_IERR, 32'd0);
        @(negedge clk);
        chk("t4_err_mcyc", 32'(m_cyc), 32'd0);
        chk("t4_err_grant", 32'(grant), 32'd0);
        chk("t4_err_ierr", 32'(i_err), 32'd1);
        next_cyc(); idle_inputs();
        @(negedge clk);
        chk("t4_idle_grant", 32'(grant), 32'd0);
        chk("t4_idle_ierr", 32'(i_err), 32'd0);

        // Ack on the threshold cycle wins over the timeout
        next_cyc(); i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h504;
        next_cyc();
        next_cyc();
        next_cyc();
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'h12345678; expect_resp(K_IACK, 32'h12345678);
        next_cyc(); m_ack = 1'b0; idle_inputs();
        @(negedge clk);
        chk("t5_after_grant", 32'(grant), 32'd1);
        chk("t5_after_ierr", 32'(i_err), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("t5_idle_grant", 32'(grant), 32'd0);

        // Reset in the middle of a data cycle
        next_cyc(); d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h600;
        next_cyc();
        @(negedge clk);
        chk("t6_own_grant", 32'(grant), 32'd2);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'h99999999; rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_dack", 32'(d_ack), 32'd0);
        chk("t6_rst_mcyc", 32'(m_cyc), 32'd0);
        next_cyc(); rst_n = 1'b1; m_ack = 1'b0;
        @(negedge clk);
        chk("t6_idle_grant", 32'(grant), 32'd0);
        next_cyc(); m_ack = 1'b1; m_dat_r = 32'hCAFEF00D; expect_resp(K_DACK, 32'hCAFEF00D);
        @(negedge clk);
        chk("t6_recover_grant", 32'(grant), 32'd2);
        chk("t6_recover_madr", m_adr, 32'h600);
        next_cyc(); m_ack = 1'b0; idle_inputs();
        next_cyc();
        @(negedge clk);
        chk("t6_end_grant", 32'(grant), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning cycles of m_stb without m_ack before a bus error is declared (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_cyc, i_stb  input  1 each  instruction-fetch master cycle and strobe; i_adr  input  32  fetch address.
REQ-005 SHALL have ports i_dat  output  32  fetch read data; i_ack, i_err  output  1 each  fetch completion and error.
REQ-006 SHALL have ports d_cyc, d_stb, d_we  input  1 each  data master controls; d_sel  input  4  byte lanes; d_adr, d_dat_w  input  32 each  address and write data.
REQ-007 SHALL have ports d_dat_r  output  32  data read data; d_ack, d_err  output  1 each  data completion and error.
REQ-008 SHALL have ports m_cyc, m_stb, m_we  output  1 each; m_sel  output  4; m_adr, m_dat_w  output  32 each  shared memory-port request.
REQ-009 SHALL have ports m_dat_r  input  32; m_ack  input  1  shared memory-port response.
REQ-010 SHALL have port grant  output  2  one-hot owner: bit0 instruction, bit1 data, 00 idle.

Function
REQ-011 SHALL implement states IDLE, OWN_I, OWN_D, ERR.
REQ-012 IDLE: i_cyc only -> OWN_I; d_cyc only -> OWN_D; both -> owner opposite to last_owner register; neither -> stay.
REQ-013 Arbitration latency SHALL be exactly one cycle: request sampled in IDLE, m_cyc asserted the following cycle.
REQ-014 In OWN_x, m_cyc SHALL equal x_cyc and m_stb, m_we, m_sel, m_adr, m_dat_w SHALL follow master x combinationally; instruction master drives m_we=0, m_sel=4'b1111, m_dat_w=0.
REQ-015 In IDLE and ERR, m_cyc, m_stb, m_we SHALL be 0 and m_sel, m_adr, m_dat_w SHALL be 0.
REQ-016 m_ack SHALL be routed only to the owning master's ack, same cycle; m_dat_r SHALL be routed to i_dat or d_dat_r of the owner, other read-data output 0.
REQ-017 m_ack in IDLE or ERR SHALL be ignored (no ack to any master).
REQ-018 Ownership SHALL be locked while owner's cyc=1; owner deasserting cyc -> IDLE next cycle, last_owner updated to that owner.
REQ-019 Non-owner requests during a locked cycle SHALL be held pending, never dropped or acknowledged.
REQ-020 8-bit timeout counter SHALL clear on entry to OWN_x and on every m_ack, increment each cycle m_stb=1 and m_ack=0, saturate never (wrap impossible by TIMEOUT range).
REQ-021 Counter reaching TIMEOUT-1 with m_ack=0 SHALL assert owner's x_err for exactly one cycle (the following cycle, state ERR), m_cyc forced 0 in ERR.
REQ-022 ERR SHALL go to IDLE unconditionally after one cycle, last_owner updated to the errored owner.
REQ-023 m_ack and timeout in same cycle: ack wins, counter clears, no error.
REQ-024 Owner dropping cyc in same cycle as timeout threshold: no error, go IDLE.
REQ-025 grant SHALL reflect current state combinationally (IDLE/ERR -> 00).

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, last_owner=data (so instruction wins first tie), counter 0, all outputs 0, independent of clk.
REQ-027 Reset mid-transaction SHALL abort silently: no ack or err issued.
REQ-028 Deassertion SHALL be synchronized externally; first arbitration on first rising edge with rst_n=1.

Structure
REQ-029 State encoding, owner IDs and TIMEOUT default SHALL live in shared package selen_bus_pkg.
REQ-030 Timeout counter SHALL be sub-module bus_timeout (inputs clear, count; output expired); rest flat.

Verification
REQ-031 Fetch alone: i_cyc/i_stb at cycle 0, adr 0x100, m_ack with m_dat_r 0xDEADBEEF at cycle 3 -> m_cyc=1 from cycle 1, i_ack=1 and i_dat=0xDEADBEEF at cycle 3, grant=01.
REQ-032 Tie after reset: both request cycle 0 -> OWN_I; after instruction releases, data granted one cycle later; next tie -> instruction.
REQ-033 Lock: data owns, write d_adr 0x200 d_dat_w 0x55 d_sel 0001; i_cyc raised mid-cycle -> no i_ack, m_adr stays 0x200 until d_cyc drops.
REQ-034 Timeout: TIMEOUT=4, fetch never acked -> i_err one-cycle pulse 4 cycles after m_stb rises, m_cyc=0 that cycle, IDLE next.
REQ-035 Ack on threshold cycle -> i_ack=1, i_err never asserted.
REQ-036 rst_n low mid-OWN_D -> all outputs 0 same cycle, no d_ack/d_err; recovery normal.
